mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Parametrised memory-stage controller for the pipeline; successor to the single-mode memory handler.
//  Accepts one op from EX, issues load/store to the data cache over a valid/ready request and
//  response handshake, aligns and sign-/zero-extends load data, and holds the result until MEM/WB accepts.
//  Adds stores, sub-word sizes, explicit FSM and back-to-back issue.
// PARAMETERS
//  ADDR_W   64  address width
//  DATA_W   64  cache word / register width (32 or 64); OFF_W = $clog2(DATA_W/8)
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-high reset
//  memory_enable    in   1        EX presents a valid op this cycle
//  memory_ready     out  1        controller can accept an op (IDLE, or DONE with mem_wb_ready)
//  mem_read         in   1        op is a load
//  mem_write        in   1        op is a store (mem_read & mem_write never both 1)
//  mem_size         in   2        0=B 1=H 2=W 3=D
//  mem_unsigned     in   1        zero-extend load
//  alu_data         in   ADDR_W   effective address
//  reg_b_contents   in   DATA_W   store data
//  cache_req_valid  out  1        request to cache
//  cache_req_ready  in   1        cache accepts request
//  cache_req_addr   out  ADDR_W   request address
//  cache_req_write  out  1        1=store
//  cache_req_wdata  out  DATA_W   lane-shifted store data
//  cache_req_wstrb  out  DATA_W/8 byte enables
//  cache_resp_valid in   1        response (load data or store ack)
//  cache_resp_rdata in   DATA_W   word-aligned read data
//  loaded_data_out  out  DATA_W   extended load result (0 for stores/non-mem ops)
//  memory_done      out  1        result valid to MEM/WB
//  mem_wb_ready     in   1        MEM/WB latches result this cycle
//  misalign_fault   out  1        qualified by memory_done
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except memory_ready=1. Mid-op reset aborts; cache shares reset.
//  FSM: IDLE -accept mem op-> REQ; IDLE -accept non-mem op-> DONE.
//   REQ: cache_req_valid=1, fields stable; on cache_req_ready -> WAIT.
//   WAIT: on cache_resp_valid capture/extend data -> DONE (resp same cycle as req_ready not allowed).
//   DONE: memory_done=1, outputs stable; on mem_wb_ready -> IDLE, or directly accept a new op
//   if memory_enable same cycle (back-to-back, no bubble).
//  Accept = memory_enable & memory_ready; op fields registered at accept.
//  Latency: non-mem op done 1 cycle after accept; mem op = 1 + req wait + resp wait + 1.
//  Load: off=addr[OFF_W-1:0]; data=rdata>>(8*off); keep 8<<size bits; sign-extend unless mem_unsigned.
//  Store: wdata=reg_b<<(8*off); wstrb=((1<<(1<<size))-1)<<off, truncated to DATA_W/8 bits.
//  DATA_W=32: mem_size 3 treated as 2.
//  Ignore cache_resp_valid outside WAIT; ignore memory_enable when memory_ready=0.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: addr not multiple of (1<<size) -> no cache request,
//   IDLE->DONE in 1 cycle, misalign_fault=1, loaded_data_out=0.
//  Undefined: misalign_fault tied 0; access issued as-is, lanes beyond word boundary dropped (read 0).
// STRUCTURE
//  mem_pkg: mem_size_e, mem_state_e {IDLE,REQ,WAIT,DONE}, byte-lane helper functions.
//  Sub-module load_align_ext (combinational shift/mask/extend), instanced once.
// TESTING
//  LB addr 0x1003, rdata 0x0000_0000_8000_0000 -> loaded_data_out=0xFFFF_FFFF_FFFF_FF80 (LBU: 0x80).
//  SH addr 0x1006, reg_b 0xBEEF -> wdata 0xBEEF_0000_0000_0000, wstrb 0xC0, write=1.
//  Cache holds req_ready low 5 cycles -> req fields stable, req_valid held, done 1 after resp.
//  mem_wb_ready low 3 cycles in DONE -> memory_done/data held; then back-to-back op accepted same cycle.
//  Reset asserted in WAIT -> next cycle IDLE, req_valid=0, memory_done=0; late resp ignored.
//  MEM_MISALIGN_TRAP_EN, LW addr 0x1002 -> no cache_req_valid, done next cycle, misalign_fault=1.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and byte-lane helpers for the memory-stage controller.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // A 32-bit datapath has no doubleword access; fold it onto a word.
  function automatic mem_size_e clamp_size(input mem_size_e sz, input int unsigned data_w);
    return ((data_w == 32) && (sz == MEM_D)) ? MEM_W : sz;
  endfunction

  function automatic logic [7:0] size_strb(input mem_size_e sz);
    case (sz)
      MEM_B:   return 8'h01;
      MEM_H:   return 8'h03;
      MEM_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] addr_lo, input mem_size_e sz);
    logic [2:0] amask;
    case (sz)
      MEM_B:   amask = 3'd0;
      MEM_H:   amask = 3'd1;
      MEM_W:   amask = 3'd3;
      default: amask = 3'd7;
    endcase
    return (addr_lo & amask) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// EX / data-cache / MEM-WB signal bundle of the memory-stage controller.
interface mem_stage_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              memory_enable;
  logic              memory_ready;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [ADDR_W-1:0] alu_data;
  logic [DATA_W-1:0] reg_b_contents;
  logic              cache_req_valid;
  logic              cache_req_ready;
  logic [ADDR_W-1:0] cache_req_addr;
  logic              cache_req_write;
  logic [DATA_W-1:0] cache_req_wdata;
  logic [STRB_W-1:0] cache_req_wstrb;
  logic              cache_resp_valid;
  logic [DATA_W-1:0] cache_resp_rdata;
  logic [DATA_W-1:0] loaded_data_out;
  logic              memory_done;
  logic              mem_wb_ready;
  logic              misalign_fault;

  modport master (
    input  memory_enable, mem_read, mem_write, mem_size, mem_unsigned, alu_data,
           reg_b_contents, cache_req_ready, cache_resp_valid, cache_resp_rdata, mem_wb_ready,
    output memory_ready, cache_req_valid, cache_req_addr, cache_req_write, cache_req_wdata,
           cache_req_wstrb, loaded_data_out, memory_done, misalign_fault
  );

  modport slave (
    output memory_enable, mem_read, mem_write, mem_size, mem_unsigned, alu_data,
           reg_b_contents, cache_req_ready, cache_resp_valid, cache_resp_rdata, mem_wb_ready,
    input  memory_ready, cache_req_valid, cache_req_addr, cache_req_write, cache_req_wdata,
           cache_req_wstrb, loaded_data_out, memory_done, misalign_fault
  );
endinterface

// File: rtl/mem_stage_ctrl_load_align_ext.sv
// Combinational load path: lane shift, size mask and sign/zero extension.
module mem_stage_ctrl_load_align_ext
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  off_i,
  input  mem_size_e         size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] ext_data_c_o
);

  logic [DATA_W-1:0] sh;

  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    case (size_i)
      MEM_B:   ext_data_c_o = unsigned_i ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
      MEM_H:   ext_data_c_o = unsigned_i ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
      MEM_W:   ext_data_c_o = unsigned_i ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
      default: ext_data_c_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: accepts an EX op, runs one cache transaction, holds result for MEM/WB.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses complete at once with misalign_fault set.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic             clk,
  input logic             reset,
  mem_stage_ctrl_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  mem_state_e        state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              unsigned_q, unsigned_d;
  mem_size_e         size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              fault_q, fault_d;

  logic              ready_c;
  logic              accept_c;
  mem_size_e         size_in_c;
  logic [OFF_W-1:0]  off_in_c;
  logic [DATA_W-1:0] load_c;

  assign ready_c   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.mem_wb_ready);
  assign accept_c  = bus.memory_enable && ready_c;
  assign size_in_c = clamp_size(mem_size_e'(bus.mem_size), DATA_W);
  assign off_in_c  = bus.alu_data[OFF_W-1:0];

  mem_stage_ctrl_load_align_ext #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_load_align_ext (
    .rdata_i      (bus.cache_resp_rdata),
    .off_i        (addr_q[OFF_W-1:0]),
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .ext_data_c_o (load_c)
  );

  // Next state; an accept in IDLE or DONE overrides the hold/return path.
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    write_d    = write_q;
    unsigned_d = unsigned_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    result_d   = result_q;
    fault_d    = fault_q;

    case (state_q)
      ST_REQ:  if (bus.cache_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (bus.cache_resp_valid) begin
        result_d = read_q ? load_c : '0;
        state_d  = ST_DONE;
      end
      ST_DONE: if (bus.mem_wb_ready) state_d = ST_IDLE;
      default: ;
    endcase

    if (accept_c) begin
      read_d     = bus.mem_read;
      write_d    = bus.mem_write;
      unsigned_d = bus.mem_unsigned;
      size_d     = size_in_c;
      addr_d     = bus.alu_data;
      wdata_d    = bus.reg_b_contents << {off_in_c, 3'b000};
      wstrb_d    = STRB_W'({8'h00, size_strb(size_in_c)} << off_in_c);
      result_d   = '0;
      fault_d    = 1'b0;
      if (!(bus.mem_read || bus.mem_write)) begin
        state_d = ST_DONE;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      else if (is_misaligned(bus.alu_data[2:0], size_in_c)) begin
        state_d = ST_DONE;
        fault_d = 1'b1;
      end
`endif
      else begin
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= MEM_B;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      result_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      result_q   <= result_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.memory_ready    = ready_c;
  assign bus.cache_req_valid = (state_q == ST_REQ);
  assign bus.cache_req_addr  = addr_q;
  assign bus.cache_req_write = write_q;
  assign bus.cache_req_wdata = wdata_q;
  assign bus.cache_req_wstrb = wstrb_q;
  assign bus.loaded_data_out = result_q;
  assign bus.memory_done     = (state_q == ST_DONE);
  assign bus.misalign_fault  = fault_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (64-bit build; trap case follows MEM_MISALIGN_TRAP_EN).
module tb_mem_stage_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mem_stage_ctrl_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_stage_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] regb);
    bus.memory_enable  = 1'b1;
    bus.mem_read       = rd;
    bus.mem_write      = wr;
    bus.mem_size       = sz;
    bus.mem_unsigned   = uns;
    bus.alu_data       = addr;
    bus.reg_b_contents = regb;
    step();
    bus.memory_enable  = 1'b0;
    bus.alu_data       = 64'h0;
    bus.reg_b_contents = 64'h0;
  endtask

  // Accept the pending request at once and answer one cycle later.
  task automatic cache_serve(input logic [63:0] rdata);
    bus.cache_req_ready = 1'b1;
    step();
    bus.cache_req_ready  = 1'b0;
    bus.cache_resp_valid = 1'b1;
    bus.cache_resp_rdata = rdata;
    step();
    bus.cache_resp_valid = 1'b0;
    bus.cache_resp_rdata = 64'h0;
  endtask

  task automatic wb_accept();
    bus.mem_wb_ready = 1'b1;
    step();
    bus.mem_wb_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                = 1'b1;
    bus.memory_enable    = 1'b0;
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.mem_size         = 2'd0;
    bus.mem_unsigned     = 1'b0;
    bus.alu_data         = 64'h0;
    bus.reg_b_contents   = 64'h0;
    bus.cache_req_ready  = 1'b0;
    bus.cache_resp_valid = 1'b0;
    bus.cache_resp_rdata = 64'h0;
    bus.mem_wb_ready     = 1'b0;
    step();
    step();
    check("rst_ready", bus.memory_ready, 1'b1);
    check("rst_req_valid", bus.cache_req_valid, 1'b0);
    check("rst_done", bus.memory_done, 1'b0);
    check("rst_data", bus.loaded_data_out, 64'h0);
    check("rst_fault", bus.misalign_fault, 1'b0);
    reset = 1'b0;
    step();

    // LB sign-extended
    send_op(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0);
    check("lb_req_valid", bus.cache_req_valid, 1'b1);
    check("lb_req_addr", bus.cache_req_addr, 64'h1003);
    check("lb_req_write", bus.cache_req_write, 1'b0);
    check("lb_ready_busy", bus.memory_ready, 1'b0);
    cache_serve(64'h0000_0000_8000_0000);
    check("lb_done", bus.memory_done, 1'b1);
    check("lb_data", bus.loaded_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    wb_accept();
    check("lb_idle_done", bus.memory_done, 1'b0);

    // LBU zero-extended
    send_op(1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'h0);
    cache_serve(64'h0000_0000_8000_0000);
    check("lbu_data", bus.loaded_data_out, 64'h0000_0000_0000_0080);
    wb_accept();

    // SH lane shift and strobes
    send_op(1'b0, 1'b1, 2'd1, 1'b0, 64'h1006, 64'h0000_0000_0000_BEEF);
    check("sh_req_write", bus.cache_req_write, 1'b1);
    check("sh_wdata", bus.cache_req_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_wstrb", bus.cache_req_wstrb, 64'hC0);
    cache_serve(64'hDEAD_BEEF_DEAD_BEEF);
    check("sh_done", bus.memory_done, 1'b1);
    check("sh_data_zero", bus.loaded_data_out, 64'h0);
    wb_accept();

    // SB and SW strobes
    send_op(1'b0, 1'b1, 2'd0, 1'b0, 64'h3005, 64'h1122_3344_5566_77AA);
    check("sb_wdata", bus.cache_req_wdata, 64'h6677_AA00_0000_0000);
    check("sb_wstrb", bus.cache_req_wstrb, 64'h20);
    cache_serve(64'h0);
    wb_accept();
    send_op(1'b0, 1'b1, 2'd2, 1'b0, 64'h3004, 64'h0000_0000_CAFE_F00D);
    check("sw_wdata", bus.cache_req_wdata, 64'hCAFE_F00D_0000_0000);
    check("sw_wstrb", bus.cache_req_wstrb, 64'hF0);
    cache_serve(64'h0);
    wb_accept();

    // LD full word
    send_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h3000, 64'h0);
    check("ld_wstrb", bus.cache_req_wstrb, 64'hFF);
    cache_serve(64'h8123_4567_89AB_CDEF);
    check("ld_data", bus.loaded_data_out, 64'h8123_4567_89AB_CDEF);
    wb_accept();

    // LW with cache stalling the request for 5 cycles
    send_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h2004, 64'h0);
    for (int i = 0; i < 5; i++) begin
      bus.cache_resp_valid = (i == 1);
      bus.cache_resp_rdata = 64'h1111_1111_1111_1111;
      bus.memory_enable    = (i == 2);
      bus.mem_write        = 1'b1;
      bus.mem_read         = 1'b0;
      bus.alu_data         = 64'h9999;
      check("stall_req_valid", bus.cache_req_valid, 1'b1);
      check("stall_req_addr", bus.cache_req_addr, 64'h2004);
      check("stall_req_write", bus.cache_req_write, 1'b0);
      step();
    end
    bus.cache_resp_valid = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.alu_data         = 64'h0;
    check("stall_done_early", bus.memory_done, 1'b0);
    bus.cache_req_ready = 1'b1;
    step();
    bus.cache_req_ready = 1'b0;
    check("stall_wait_valid", bus.cache_req_valid, 1'b0);
    check("stall_wait_done", bus.memory_done, 1'b0);
    bus.cache_resp_valid = 1'b1;
    bus.cache_resp_rdata = 64'h8765_4321_0000_0000;
    step();
    bus.cache_resp_valid = 1'b0;
    check("stall_done", bus.memory_done, 1'b1);
    check("stall_data", bus.loaded_data_out, 64'hFFFF_FFFF_8765_4321);

    // MEM/WB back-pressure for 3 cycles, then back-to-back accept
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_done", bus.memory_done, 1'b1);
      check("hold_data", bus.loaded_data_out, 64'hFFFF_FFFF_8765_4321);
      check("hold_ready", bus.memory_ready, 1'b0);
    end
    bus.mem_wb_ready  = 1'b1;
    bus.memory_enable = 1'b1;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    #1;
    check("b2b_ready", bus.memory_ready, 1'b1);
    step();
    bus.mem_wb_ready  = 1'b0;
    bus.memory_enable = 1'b0;
    check("b2b_done", bus.memory_done, 1'b1);
    check("b2b_data", bus.loaded_data_out, 64'h0);
    check("b2b_req_valid", bus.cache_req_valid, 1'b0);
    wb_accept();
    check("b2b_idle", bus.memory_done, 1'b0);

`ifndef MEM_MISALIGN_TRAP_EN
    // Upper lanes beyond the word read as zero
    send_op(1'b1, 1'b0, 2'd1, 1'b0, 64'h3007, 64'h0);
    cache_serve(64'hAB00_0000_0000_0000);
    check("lh_edge_data", bus.loaded_data_out, 64'h0000_0000_0000_00AB);
    wb_accept();
`endif

    // Reset during WAIT aborts the op; a late response is ignored
    send_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'h0);
    bus.cache_req_ready = 1'b1;
    step();
    bus.cache_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_req_valid", bus.cache_req_valid, 1'b0);
    check("abort_done", bus.memory_done, 1'b0);
    check("abort_ready", bus.memory_ready, 1'b1);
    bus.cache_resp_valid = 1'b1;
    bus.cache_resp_rdata = 64'h5555_5555_5555_5555;
    step();
    bus.cache_resp_valid = 1'b0;
    check("late_resp_done", bus.memory_done, 1'b0);
    check("late_resp_data", bus.loaded_data_out, 64'h0);

    // Misaligned LW
    send_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("trap_req_valid", bus.cache_req_valid, 1'b0);
    check("trap_done", bus.memory_done, 1'b1);
    check("trap_fault", bus.misalign_fault, 1'b1);
    check("trap_data", bus.loaded_data_out, 64'h0);
    wb_accept();
    check("trap_idle", bus.memory_done, 1'b0);
`else
    check("mis_req_valid", bus.cache_req_valid, 1'b1);
    check("mis_req_addr", bus.cache_req_addr, 64'h1002);
    cache_serve(64'h0000_8899_AABB_0000);
    check("mis_done", bus.memory_done, 1'b1);
    check("mis_fault", bus.misalign_fault, 1'b0);
    check("mis_data", bus.loaded_data_out, 64'hFFFF_FFFF_8899_AABB);
    wb_accept();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
